// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

   localparam int unsigned STATE_W       = 2;
   localparam int unsigned SEL_W_DEFAULT = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1-style mux select through every channel and collects y into a word
// presented under valid/ack. Optional parity output when MUX_SCAN_PARITY_EN is defined.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned SEL_W = SEL_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_in,
   input  logic               y_in,
   output logic [SEL_W-1:0]   sel_out,
   output logic [(2**SEL_W)-1:0] capture_out,
   output logic               valid_out,
   output logic               busy_out,
   input  logic               ack_in
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic               parity_out
`endif
);

   localparam int unsigned N = 2**SEL_W;

   scan_state_t  state;
   logic [N-1:0] capture_nxt_c;

   // Capture word as it will look after this cycle's sample is written.
   always_comb begin
      capture_nxt_c          = capture_out;
      capture_nxt_c[sel_out] = y_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sel_out     <= '0;
         capture_out <= '0;
         valid_out   <= 1'b0;
         busy_out    <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         parity_out  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_in) begin
                  state       <= SCAN;
                  sel_out     <= '0;
                  capture_out <= '0;
                  busy_out    <= 1'b1;
               end
            end
            SCAN: begin
               capture_out <= capture_nxt_c;
               sel_out     <= sel_out + SEL_W'(1);
               if (sel_out == SEL_W'(N-1)) begin
                  state     <= DONE;
                  valid_out <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                  parity_out <= ^capture_nxt_c;
`endif
               end
            end
            DONE: begin
               // start_in is deliberately ignored here, even alongside ack_in.
               if (ack_in) begin
                  state     <= IDLE;
                  valid_out <= 1'b0;
                  busy_out  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               valid_out <= 1'b0;
               busy_out  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl driving a behavioural 4:1 mux.
// Parity checks are compiled in when MUX_SCAN_PARITY_EN is defined.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_in;
   logic       ack_in;
   logic [3:0] data_in;
   logic       y;
   logic [1:0] sel_out;
   logic [3:0] capture_out;
   logic       valid_out;
   logic       busy_out;
`ifdef MUX_SCAN_PARITY_EN
   logic       parity_out;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Behavioural mux sitting beside the sequencer.
   assign y = data_in[sel_out];

   mux_scan_ctrl #(.SEL_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_in    (start_in),
      .y_in        (y),
      .sel_out     (sel_out),
      .capture_out (capture_out),
      .valid_out   (valid_out),
      .busy_out    (busy_out),
      .ack_in      (ack_in)
`ifdef MUX_SCAN_PARITY_EN
      ,
      .parity_out  (parity_out)
`endif
   );

   typedef struct {
      logic [3:0] data;
      logic [3:0] exp_cap;
      logic       exp_par;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag, input logic [3:0] exp_cap);
      check({tag, "_sel"},   32'(sel_out),     32'd0);
      check({tag, "_cap"},   32'(capture_out), 32'(exp_cap));
      check({tag, "_valid"}, 32'(valid_out),   32'd0);
      check({tag, "_busy"},  32'(busy_out),    32'd0);
   endtask

   // One full scan from IDLE, optionally acknowledged at the end.
   task automatic do_scan(input logic [3:0] d, input logic [3:0] exp_cap,
                          input logic exp_par, input bit do_ack);
      data_in  = d;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check("start_cap", 32'(capture_out), 32'd0);
      for (int k = 0; k < 4; k++) begin
         check("scan_sel",   32'(sel_out),   32'(k));
         check("scan_busy",  32'(busy_out),  32'd1);
         check("scan_valid", 32'(valid_out), 32'd0);
         tick();
      end
      check("done_valid", 32'(valid_out),   32'd1);
      check("done_cap",   32'(capture_out), 32'(exp_cap));
      check("done_sel",   32'(sel_out),     32'd0);
      check("done_busy",  32'(busy_out),    32'd1);
`ifdef MUX_SCAN_PARITY_EN
      check("done_parity", 32'(parity_out), 32'(exp_par));
`else
      if (exp_par === 1'bx) $display("note: unexpected X parity in table");
`endif
      if (do_ack) begin
         ack_in = 1'b1;
         tick();
         ack_in = 1'b0;
         check_idle("ack", exp_cap);
      end
   endtask

   initial begin
      int waited;
      rst      = 1'b1;
      start_in = 1'b0;
      ack_in   = 1'b0;
      data_in  = 4'b0000;

      // 1: reset state
      tick();
      tick();
      check_idle("reset", 4'b0000);
`ifdef MUX_SCAN_PARITY_EN
      check("reset_parity", 32'(parity_out), 32'd0);
`endif
      rst = 1'b0;
      tick();
      check_idle("idle_hold", 4'b0000);

      // Table-driven scans with ack
      vecs[0] = '{4'b0101, 4'b0101, 1'b0};
      vecs[1] = '{4'b1010, 4'b1010, 1'b0};
      vecs[2] = '{4'b0000, 4'b0000, 1'b0};
      vecs[3] = '{4'b1111, 4'b1111, 1'b0};
      vecs[4] = '{4'b0111, 4'b0111, 1'b1};
      vecs[5] = '{4'b1000, 4'b1000, 1'b1};
      vecs[6] = '{4'b0110, 4'b0110, 1'b0};
      for (int i = 0; i < 7; i++)
         do_scan(vecs[i].data, vecs[i].exp_cap, vecs[i].exp_par, 1'b1);

      // 3: long hold in DONE without ack, data changing underneath
      do_scan(4'b1010, 4'b1010, 1'b0, 1'b0);
      data_in = 4'b0101;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("hold_valid", 32'(valid_out),   32'd1);
         check("hold_cap",   32'(capture_out), 32'ha);
         check("hold_sel",   32'(sel_out),     32'd0);
      end
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      check_idle("hold_ack", 4'b1010);

      // 4: start mid-scan ignored; start+ack together in DONE returns to IDLE
      data_in  = 4'b0011;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      tick();
      check("mid_sel1", 32'(sel_out), 32'd1);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check("mid_sel2", 32'(sel_out), 32'd2);
      waited = 0;
      while (valid_out !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check("mid_valid_latency", 32'(waited), 32'd2);
      check("mid_cap", 32'(capture_out), 32'h3);
      start_in = 1'b1;
      ack_in   = 1'b1;
      tick();
      start_in = 1'b0;
      ack_in   = 1'b0;
      check_idle("start_ack", 4'b0011);
      tick();
      check_idle("no_restart", 4'b0011);

      // 5: reset mid-scan at sel_out == 2, then a fresh scan
      data_in  = 4'b1111;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      tick();
      tick();
      check("pre_rst_sel", 32'(sel_out), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("mid_rst", 4'b0000);
      tick();
      check_idle("post_rst", 4'b0000);
      do_scan(4'b1100, 4'b1100, 1'b0, 1'b1);

      // Reset while in DONE also clears everything
      do_scan(4'b0111, 4'b0111, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("done_rst", 4'b0000);
`ifdef MUX_SCAN_PARITY_EN
      check("done_rst_parity", 32'(parity_out), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits around the behavioural 4:1 mux (`data_in`, `sel_in`, `y`). It drives the mux select input through every channel in order and collects the mux output `y` one bit per cycle into a parallel capture word. When the scan is done it presents that word under a valid/ack handshake. It is the stage that drives the mux and consumes what it produces, so a parent can read all mux inputs through the single-bit output path.

## Interface
Parameters:
- `SEL_W`, default 2: select width. Number of mux channels is `N = 2**SEL_W`.

Ports:
- `clk`: input, width 1. Single clock; all state updates on the rising edge.
- `rst`: input, width 1. Synchronous, active-high reset.
- `start_in`: input, width 1. Scan request; sampled only in IDLE.
- `y_in`: input, width 1. Mux output (`y`), combinational from `sel_out`.
- `sel_out`: output, width `SEL_W`. Drives the mux `sel_in`; registered.
- `capture_out`: output, width `N`. Collected word; bit k equals `y_in` observed while `sel_out == k`.
- `valid_out`: output, width 1. Capture word is complete and stable.
- `busy_out`: output, width 1. High in SCAN and DONE.
- `ack_in`: input, width 1. Consumer has taken `capture_out`; sampled only in DONE.
- `parity_out`: output, width 1. Present only when `MUX_SCAN_PARITY_EN` is defined.

## Operation
- Reset, on any edge with `rst=1`, at any time including mid-scan:
  - state = IDLE
  - `sel_out` = 0, `capture_out` = 0
  - `valid_out` = 0, `busy_out` = 0, `parity_out` = 0
  - `rst` has priority over every other input.
- States: IDLE, SCAN, DONE.
- **IDLE**
  - `start_in=1` at an edge: go to SCAN, `sel_out` = 0, `capture_out` = 0.
  - Otherwise hold.
- **SCAN**, at each edge:
  - `capture_out[sel_out]` <= `y_in`.
  - If `sel_out == N-1`: go to DONE and set `valid_out` = 1. `sel_out` wraps to 0.
  - Otherwise `sel_out` increments by 1.
  - `start_in` and `ack_in` are ignored.
- **DONE**
  - `capture_out` and `sel_out` (= 0) are held.
  - `ack_in=1` at an edge: go to IDLE and clear `valid_out`. `capture_out` keeps its last value until the next scan begins.
  - `start_in` is ignored, including on the same edge as `ack_in`. A new scan needs `start_in` in IDLE, so there are no back-to-back scans.
- `busy_out` = (state != IDLE), registered.
- The counter is exactly `SEL_W` bits and wraps modulo N. No other arithmetic.

## Timing
- Start edge E0 enters SCAN with `sel_out=0`. Edges E1..EN capture bits 0..N-1.
- `valid_out` is high after EN, i.e. N+1 edges after the start edge (5 edges for `SEL_W=2`).
- `y_in` must settle within one cycle of a `sel_out` change. The mux is purely combinational, so this holds.
- `ack_in` to `valid_out` low: 1 edge.
- Minimum start-to-start period: N+3 edges (N+1 to valid, 1 for ack, 1 in IDLE).

## Configuration
- `MUX_SCAN_PARITY_EN` defined:
  - Adds port `parity_out` = XOR-reduce of `capture_out`.
  - It is registered, updates on the same edge `valid_out` rises, is held through DONE, and is cleared by reset.
- `MUX_SCAN_PARITY_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `mux_scan_pkg`:
  - State enum typedef `scan_state_t` (IDLE, SCAN, DONE).
  - Its 2-bit width constant.
  - Default `SEL_W` constant.
- No sub-module. The counter and FSM are small enough for one module.
- The mux itself is instantiated beside this block in the parent, with `sel_out`→`sel_in` and `y`→`y_in`.

## Test plan
The bench instantiates `mux_scan_ctrl` with a 4:1 mux. Each scenario uses a task-based stimulus and checks with `$display` per cycle.
1. Hold `rst=1` for 2 edges -> `sel_out=0`, `capture_out=0`, `valid_out=0`, `busy_out=0`.
2. Mux `data_in=4'b0101`, one-cycle `start_in` -> `sel_out` steps 0,1,2,3; `valid_out` rises 5 edges after start; `capture_out=4'b0101`; `busy_out=1` throughout.
3. `data_in=4'b1010`, `ack_in` held low 10 cycles after valid -> `capture_out=4'b1010` and `valid_out=1` stable. Raise ack -> IDLE and `valid_out=0` one edge later.
4. Pulse `start_in` mid-SCAN, then assert `start_in` and `ack_in` together in DONE -> no restart, `sel_out` sequence unaffected, returns to IDLE, `busy_out=0`.
5. Assert `rst` when `sel_out=2` -> next edge all outputs 0 and IDLE. A fresh start with `data_in=4'b1100` yields `capture_out=4'b1100`.
6. With `MUX_SCAN_PARITY_EN`, `data_in=4'b0111` -> `parity_out=1` when valid. With `data_in=4'b0101` -> `parity_out=0`.
